// File: rtl/if_network_sequencer.sv
// if_network_sequencer: runs one if_network instance through one
// classification sample. On an accepted start it clears the network, applies
// the latched input pattern for num_steps cycles, drains in-flight spikes with
// zero input, and accumulates saturating per-output spike counts.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           single-cycle request, sampled only in IDLE
//   pattern         input spike pattern, latched on an accepted start
//   num_steps       run length in timesteps, latched on an accepted start
//   busy            high in every state except IDLE
//   done            one-cycle pulse in DONE
//   net_rst         network reset: rst OR (state == CLEAR), combinational
//   net_spike_in    drive to if_network spike_in
//   net_spike_out   spike_out from if_network
//   spike_count     per-output counts, output k at [k*CNT_W +: CNT_W]
//
// Optional build macro IF_SEQ_WINNER_EN adds winner / winner_valid: the index
// of the largest count (lowest index on ties), valid from DONE until the next
// accepted start or rst.
module if_network_sequencer #(
    parameter int unsigned NUM_INPUTS   = 4,
    parameter int unsigned NUM_OUTPUTS  = 1,
    parameter int unsigned STEP_W       = 16,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_INPUTS-1:0]          pattern,
    input  logic [STEP_W-1:0]              num_steps,
    output logic                           busy,
    output logic                           done,
    output logic                           net_rst,
    output logic [NUM_INPUTS-1:0]          net_spike_in,
    input  logic [NUM_OUTPUTS-1:0]         net_spike_out,
    output logic [NUM_OUTPUTS*CNT_W-1:0]   spike_count
`ifdef IF_SEQ_WINNER_EN
    ,
    output logic [((NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1)-1:0] winner,
    output logic                           winner_valid
`endif
);

    // Phase counter covers the longer of the CLEAR and DRAIN windows.
    localparam int unsigned PH_MAX = (CLEAR_CYCLES > DRAIN_CYCLES) ? CLEAR_CYCLES : DRAIN_CYCLES;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                          state;
    state_t                          state_next;
    logic [PH_W-1:0]                 phase;
    logic [PH_W-1:0]                 phase_next;
    logic [STEP_W-1:0]               step_cnt;
    logic [STEP_W-1:0]               step_next;
    logic [STEP_W-1:0]               steps_q;
    logic [NUM_INPUTS-1:0]           pat_q;
    logic [NUM_OUTPUTS*CNT_W-1:0]    cnt_next;
    logic                            accept;

    assign accept  = (state == IDLE) && start;
    assign net_rst = rst || (state == CLEAR);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and phase/step counter logic.
    always_comb begin
        state_next = state;
        phase_next = phase;
        step_next  = step_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CLEAR;
                    phase_next = '0;
                    step_next  = num_steps;
                end
            end
            CLEAR: begin
                if (phase == PH_W'(CLEAR_CYCLES - 1)) begin
                    phase_next = '0;
                    state_next = (steps_q == '0) ? DRAIN : RUN;
                end else begin
                    phase_next = phase + PH_W'(1);
                end
            end
            RUN: begin
                if (step_cnt <= STEP_W'(1)) begin
                    state_next = DRAIN;
                    step_next  = '0;
                end else begin
                    step_next = step_cnt - STEP_W'(1);
                end
            end
            DRAIN: begin
                if (phase == PH_W'(DRAIN_CYCLES - 1)) begin
                    phase_next = '0;
                    state_next = DONE;
                end else begin
                    phase_next = phase + PH_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Saturating per-output counters; cleared on accept, counting only in RUN/DRAIN.
    always_comb begin
        cnt_next = spike_count;
        if (accept) begin
            cnt_next = '0;
        end else if ((state == RUN) || (state == DRAIN)) begin
            for (int k = 0; k < NUM_OUTPUTS; k++) begin
                if (net_spike_out[k] && (spike_count[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    cnt_next[k*CNT_W +: CNT_W] = spike_count[k*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    // Datapath registers and registered state decodes (valid in the occupied state).
    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= '0;
            step_cnt     <= '0;
            steps_q      <= '0;
            pat_q        <= '0;
            spike_count  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            net_spike_in <= '0;
        end else begin
            phase       <= phase_next;
            step_cnt    <= step_next;
            spike_count <= cnt_next;
            if (accept) begin
                steps_q <= num_steps;
                pat_q   <= pattern;
            end
            busy         <= (state_next != IDLE);
            done         <= (state_next == DONE);
            net_spike_in <= (state_next == RUN) ? pat_q : '0;
        end
    end

`ifdef IF_SEQ_WINNER_EN
    localparam int unsigned WIN_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    logic [WIN_W-1:0] win_idx;
    logic [CNT_W-1:0] win_max;

    // Argmax over the final counts; strict compare keeps the lowest index on ties.
    always_comb begin
        win_idx = '0;
        win_max = cnt_next[CNT_W-1:0];
        for (int k = 1; k < NUM_OUTPUTS; k++) begin
            if (cnt_next[k*CNT_W +: CNT_W] > win_max) begin
                win_max = cnt_next[k*CNT_W +: CNT_W];
                win_idx = WIN_W'(k);
            end
        end
    end

    // Captured on the edge entering DONE so the result is visible during DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            winner       <= '0;
            winner_valid <= 1'b0;
        end else if (accept) begin
            winner       <= '0;
            winner_valid <= 1'b0;
        end else if ((state == DRAIN) && (state_next == DONE)) begin
            winner       <= win_idx;
            winner_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_network_sequencer.sv
// Self-checking bench for if_network_sequencer (default parameters).
// A per-cycle scoreboard holds the expected {busy, done, net_rst,
// net_spike_in, spike_count} for the next cycle, pushed as stimulus is
// driven and popped when the DUT shows that cycle.
module tb_if_network_sequencer;

    localparam int CC = 2;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  pattern;
    logic [15:0] num_steps;
    logic        busy;
    logic        done;
    logic        net_rst;
    logic [3:0]  net_spike_in;
    logic [0:0]  net_spike_out;
    logic [7:0]  spike_count;
`ifdef IF_SEQ_WINNER_EN
    logic [0:0]  winner;
    logic        winner_valid;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [14:0] sb_q[$];

    always #5 clk = ~clk;

    if_network_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pattern       (pattern),
        .num_steps     (num_steps),
        .busy          (busy),
        .done          (done),
        .net_rst       (net_rst),
        .net_spike_in  (net_spike_in),
        .net_spike_out (net_spike_out),
        .spike_count   (spike_count)
`ifdef IF_SEQ_WINNER_EN
        ,
        .winner        (winner),
        .winner_valid  (winner_valid)
`endif
    );

    // Expected {busy, done, net_rst, net_spike_in} for cycle i after start (i=1 first CLEAR cycle).
    function automatic logic [6:0] exp_ctrl(input int i, input int steps, input logic [3:0] pat);
        int total;
        total = CC + steps + DC + 1;
        if (i >= 1 && i <= CC)                  return {3'b101, 4'b0000};
        if (i > CC && i <= CC + steps)          return {3'b100, pat};
        if (i > CC + steps && i < total)        return {3'b100, 4'b0000};
        if (i == total)                         return {3'b110, 4'b0000};
        return 7'b0000000;
    endfunction

    // Spike stimulus per cycle: 0 none, 1 fixed scattered set, 2 always.
    function automatic logic spike_at(input int mode, input int i);
        if (mode == 2) return 1'b1;
        if (mode == 1) return (i == 2 || i == 3 || i == 5 || i == 7 || i == 9 ||
                               i == 12 || i == 13 || i == 14);
        return 1'b0;
    endfunction

    // One full sequence; must be entered just after a negedge with the DUT idle.
    task automatic run_seq(input string name, input logic [3:0] pat, input int steps,
                           input int mode, input int extra, input int restart_at);
        int total;
        int last;
        int cnt;
        logic [14:0] exp_v;
        logic [14:0] act_v;
        total = CC + steps + DC + 1;
        last  = total + extra;
        cnt   = 0;
        pattern       = pat;
        num_steps     = 16'(steps);
        start         = 1'b1;
        net_spike_out = 1'b0;
        sb_q.push_back({exp_ctrl(1, steps, pat), 8'd0});
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            start     = 1'b0;
            pattern   = ~pat;
            num_steps = 16'(steps + 7);
            if (i == restart_at) start = 1'b1;
            act_v = {busy, done, net_rst, net_spike_in, spike_count};
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL %s cycle %0d: scoreboard empty, got %h", name, i, act_v);
            end else begin
                exp_v = sb_q.pop_front();
                if (act_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: got busy=%b done=%b net_rst=%b spike_in=%b count=%0d, want busy=%b done=%b net_rst=%b spike_in=%b count=%0d",
                             name, i, act_v[14], act_v[13], act_v[12], act_v[11:8], act_v[7:0],
                             exp_v[14], exp_v[13], exp_v[12], exp_v[11:8], exp_v[7:0]);
                end
            end
            net_spike_out = spike_at(mode, i);
            if (net_spike_out[0] && i > CC && i < total && cnt < 255) cnt++;
            if (i < last) sb_q.push_back({exp_ctrl(i + 1, steps, pat), 8'(cnt)});
        end
        start = 1'b0;
        net_spike_out = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        pattern = 4'hF;
        num_steps = 16'd3;
        net_spike_out = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, net_rst, net_spike_in, spike_count} !== {3'b001, 4'b0000, 8'd0}) begin
            n_bad++;
            $display("FAIL reset_hold: got busy=%b done=%b net_rst=%b spike_in=%b count=%0d, want 0/0/1/0000/0",
                     busy, done, net_rst, net_spike_in, spike_count);
        end
        rst = 1'b0;
        start = 1'b0;
        net_spike_out = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, net_rst, net_spike_in, spike_count} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_release: got busy=%b done=%b net_rst=%b spike_in=%b count=%0d, want all 0",
                     busy, done, net_rst, net_spike_in, spike_count);
        end
    endtask

    task automatic test_basic();
        run_seq("basic", 4'b1010, 5, 1, 3, 0);
    endtask

    task automatic test_zero_steps();
        run_seq("zero_steps", 4'b1111, 0, 2, 2, 0);
    endtask

    task automatic test_ignore_start();
        run_seq("ignore_start", 4'b0011, 6, 1, 1, 5);
    endtask

    task automatic test_saturation();
        run_seq("saturation", 4'b0101, 300, 2, 2, 0);
    endtask

    task automatic test_rst_mid_run();
        pattern = 4'b1100;
        num_steps = 16'd10;
        start = 1'b1;
        net_spike_out = 1'b1;
        for (int i = 1; i <= CC + 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        // Cycle CC+4 is the fourth RUN cycle; three RUN cycles already counted.
        n_cmp++;
        if ({busy, net_rst, net_spike_in, spike_count} !== {2'b10, 4'b1100, 8'd3}) begin
            n_bad++;
            $display("FAIL rst_mid_run_pre: got busy=%b net_rst=%b spike_in=%b count=%0d, want 1/0/1100/3",
                     busy, net_rst, net_spike_in, spike_count);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (net_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_run_netrst: got net_rst=%b, want 1", net_rst);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, net_rst, net_spike_in, spike_count} !== {3'b001, 4'b0000, 8'd0}) begin
            n_bad++;
            $display("FAIL rst_mid_run_after: got busy=%b done=%b net_rst=%b spike_in=%b count=%0d, want 0/0/1/0000/0",
                     busy, done, net_rst, net_spike_in, spike_count);
        end
        rst = 1'b0;
        net_spike_out = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, done, net_rst, net_spike_in, spike_count} !== 15'd0) begin
            n_bad++;
            $display("FAIL rst_mid_run_idle: got busy=%b done=%b net_rst=%b spike_in=%b count=%0d, want all 0",
                     busy, done, net_rst, net_spike_in, spike_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pattern = 4'b0000;
        num_steps = 16'd0;
        net_spike_out = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_steps();
        test_ignore_start();
        test_rst_mid_run();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_network_sequencer.md
Name: if_network_sequencer

Overview:
- Inference sequencer that drives one `if_network` instance through one classification sample.
- On `start` it:
  - clears the network,
  - latches the input spike pattern,
  - applies that pattern for a programmable number of timesteps (one timestep = one clk cycle),
  - drains in-flight spikes,
  - accumulates per-output spike counts.
- Sits between the host/stimulus logic and `if_network`. It owns the network's reset and `spike_in`, and reads `spike_out`.

Parameters:
- NUM_INPUTS, 4, width of the input spike vector; matches `if_network` NUM_INPUTS.
- NUM_OUTPUTS, 1, width of the network output spike vector.
- STEP_W, 16, width of `num_steps`.
- CNT_W, 8, width of each per-output spike counter.
- CLEAR_CYCLES, 2, cycles `net_rst` is held high before the run (must be ≥1).
- DRAIN_CYCLES, 4, cycles of zero input after the run; covers network latency (NUM_LAYERS plus margin).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- pattern  in  NUM_INPUTS  input spike pattern; latched on an accepted start.
- num_steps  in  STEP_W  run length in timesteps; latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- net_rst  out  1  reset to `if_network`.
- net_spike_in  out  NUM_INPUTS  to `if_network` `spike_in`.
- net_spike_out  in  NUM_OUTPUTS  from `if_network` `spike_out`.
- spike_count  out  NUM_OUTPUTS*CNT_W  per-output counts; output k occupies bits [k*CNT_W +: CNT_W].

Behaviour:
- Reset values:
  - State = IDLE.
  - busy = 0, done = 0.
  - net_spike_in = 0.
  - spike_count = 0.
  - Latched pattern, latched steps and the step counter = 0.
- net_rst is combinational: rst OR (state == CLEAR). The network is therefore held in reset while this block is in reset.
- Outputs busy, done and net_spike_in are registered state decodes. They are valid in the cycle the state is occupied.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - start = 1 latches pattern and num_steps, clears all spike_count fields to 0, loads the step counter, and moves to CLEAR.
  - start = 0 holds the state.
- CLEAR:
  - net_rst = 1, net_spike_in = 0.
  - Lasts exactly CLEAR_CYCLES cycles.
  - Then goes to RUN, or directly to DRAIN if the latched num_steps == 0.
- RUN:
  - net_spike_in = latched pattern, every cycle.
  - Lasts exactly num_steps cycles, then goes to DRAIN.
- DRAIN:
  - net_spike_in = 0.
  - Lasts exactly DRAIN_CYCLES cycles, then goes to DONE.
- DONE:
  - done = 1 for one cycle, then IDLE.
  - busy = 1 in DONE and drops to 0 in the following IDLE cycle.
- Cycle budget: start accepted at edge N gives CLEAR on cycles N+1..N+CLEAR_CYCLES. RUN follows for num_steps cycles, DRAIN for DRAIN_CYCLES, then DONE for 1. Total busy cycles = CLEAR_CYCLES + num_steps + DRAIN_CYCLES + 1.
- Counting:
  - spike_count[k] increments by 1 on each cycle in RUN or DRAIN where net_spike_out[k] = 1.
  - No counting occurs in IDLE, CLEAR or DONE.
  - Counters saturate at 2^CNT_W−1; they do not wrap.
  - spike_count holds its final value through DONE and IDLE until the next accepted start.
- pattern and num_steps may change while busy; only the latched copies are used.
- start while busy is ignored: no queueing and no restart.
- rst in any state returns the block to the reset values on the next edge. The partial run is discarded.

Optional Feature:
- Macro: IF_SEQ_WINNER_EN.
- Defined:
  - Adds output `winner` (width $clog2(NUM_OUTPUTS), minimum 1).
  - Adds output `winner_valid` (1 bit).
  - In DONE, the block registers the index of the largest spike_count. Ties resolve to the lowest index.
  - winner_valid = 1 from DONE until the next accepted start or rst.
  - If all counts are 0, winner = 0 and winner_valid = 1.
  - Reset values: both outputs 0.
- Undefined: neither port exists, and no comparison logic is built.

Test Plan:
- Reset, then start with pattern = 4'b1010, num_steps = 5 (defaults) → net_rst high for 2 cycles; net_spike_in = 1010 for exactly 5 cycles; then 0000 for 4 cycles; done pulses once; busy high for 12 cycles.
- Bench drives net_spike_out = 1 on 3 RUN cycles, 1 DRAIN cycle and 2 IDLE cycles → spike_count = 4, held after done.
- num_steps = 0 → CLEAR goes directly to DRAIN; net_spike_in never nonzero; done after 2 + 4 + 1 cycles; busy high 7 cycles.
- CNT_W = 2, net_spike_out held at 1 with num_steps = 10 → spike_count saturates at 3.
- start re-pulsed mid-RUN with a new pattern, plus rst asserted mid-RUN on a second run → the first is ignored (the original pattern continues). For the second: next cycle busy = 0, net_spike_in = 0, spike_count = 0; net_rst is high while rst is high.
- With IF_SEQ_WINNER_EN, NUM_OUTPUTS = 2, output counts 3 and 3 → winner = 0, winner_valid = 1 from DONE; cleared on the next start.
